// File: rtl/axis_frame_padder_pkg.sv
// Shared datapath definitions for the receive-chain frame padder:
// FSM state encoding, counter width, padding fill default and the
// non-wrapping "next count reaches the frame length" test.
package axis_frame_padder_pkg;

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,   // forwarding input beats
        ST_PAD  = 2'd1,   // input ended early, emitting fill beats
        ST_DROP = 2'd2    // frame too long, discarding the tail
    } pad_state_e;

    localparam int CNT_WIDTH = 32;

    // Fill bit replicated across the data path to form the default pad word.
    localparam logic PAD_FILL_BIT = 1'b0;

    // True when cnt+1 equals max_v; evaluated at 33 bits so cnt+1 never wraps.
    function automatic logic cnt_hits_max(input logic [CNT_WIDTH-1:0] cnt,
                                          input logic [CNT_WIDTH-1:0] max_v);
        logic [CNT_WIDTH:0] inc;
        inc = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
        return inc == {1'b0, max_v};
    endfunction

endpackage

// File: rtl/axis_frame_padder.sv
// Forces every output frame to exactly oFrameNumMax beats: short frames are
// padded with PAD_WORD, long frames are cut at the limit and their tail is
// dropped (flagged on the sticky o_trunc). oFrameNumMax == 0 passes frames
// through unchanged. The output is a single registered AXI-Stream stage.
module axis_frame_padder
    import axis_frame_padder_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] PAD_WORD   = {DATA_WIDTH{PAD_FILL_BIT}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           oFrameNumMax,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_hsked,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  o_trunc
);

    pad_state_e            r_state, w_state_next;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_next;
    logic [CNT_WIDTH-1:0]  r_max_q, w_max_next;
    logic                  r_tvalid, w_tvalid_next;
    logic [DATA_WIDTH-1:0] r_tdata, w_tdata_next;
    logic                  r_tlast, w_tlast_next;
    logic                  r_trunc, w_trunc_next;

    logic                  w_load_ok;
    logic                  w_s_tready;
    logic [CNT_WIDTH-1:0]  w_max_eff;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_hit;

    // The output register may be (re)loaded when empty or being drained.
    assign w_load_ok = !r_tvalid || m_axis_tready;

    // The first beat of a frame uses the live limit (it is latched on that
    // same beat); every later beat uses the frozen copy, so limit changes
    // mid-frame never affect the frame in flight.
    assign w_max_eff = (r_state == ST_PASS && r_cnt == '0) ? oFrameNumMax : r_max_q;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_hit     = cnt_hits_max(r_cnt, w_max_eff);

    // State, counter, limit, output stage and sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_PASS;
            r_cnt    <= '0;
            r_max_q  <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_trunc  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_max_q  <= w_max_next;
            r_tvalid <= w_tvalid_next;
            r_tdata  <= w_tdata_next;
            r_tlast  <= w_tlast_next;
            r_trunc  <= w_trunc_next;
        end
    end

    // Next-state, counter and output-stage loading for PASS / PAD / DROP.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_max_next    = r_max_q;
        w_tvalid_next = r_tvalid;
        w_tdata_next  = r_tdata;
        w_tlast_next  = r_tlast;
        w_trunc_next  = r_trunc;
        w_s_tready    = 1'b0;

        // A drained stage empties unless something below reloads it.
        if (w_load_ok) begin
            w_tvalid_next = 1'b0;
        end

        case (r_state)
            ST_PASS: begin
                w_s_tready = w_load_ok;
                if (s_axis_tvalid && w_load_ok) begin
                    if (r_cnt == '0) begin
                        w_max_next = oFrameNumMax;
                    end
                    w_tvalid_next = 1'b1;
                    w_tdata_next  = s_axis_tdata;
                    w_cnt_next    = w_cnt_inc;
                    if (w_max_eff == '0) begin
                        w_tlast_next = s_axis_tlast;
                        if (s_axis_tlast) begin
                            w_cnt_next = '0;
                        end
                    end else if (w_hit) begin
                        w_tlast_next = 1'b1;
                        w_cnt_next   = '0;
                        if (!s_axis_tlast) begin
                            w_trunc_next = 1'b1;
                            w_state_next = ST_DROP;
                        end
                    end else begin
                        w_tlast_next = 1'b0;
                        if (s_axis_tlast) begin
                            w_state_next = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (w_load_ok) begin
                    w_tvalid_next = 1'b1;
                    w_tdata_next  = PAD_WORD;
                    w_tlast_next  = w_hit;
                    if (w_hit) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_PASS;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end
            ST_DROP: begin
                w_s_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_next = ST_PASS;
                end
            end
            default: begin
                w_state_next = ST_PASS;
            end
        endcase
    end

    assign s_axis_tready = w_s_tready && !rst;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_hsked  = r_tvalid && m_axis_tready;
    assign read_data     = r_tdata;
    assign o_trunc       = r_trunc;

endmodule
